// File: rtl/vend_panel_ctrl_if.sv
// Command/response bundle between the front panel and the vending machine FSM.
// The panel (master) drives one-hot command pulses; the machine answers with beverage.
interface vend_panel_ctrl_if;
   logic coin;
   logic selection;
   logic refund;
   logic beverage;

   modport master (
      output coin,
      output selection,
      output refund,
      input  beverage
   );

   modport slave (
      input  coin,
      input  selection,
      input  refund,
      output beverage
   );
endinterface

// File: rtl/vend_panel_ctrl.sv
// Vending front-panel controller: debounces coin/select/refund inputs, issues one-hot command
// pulses, tracks credit and dispense timeout. Optional dispense counter under VEND_PANEL_STATS_EN.
module vend_panel_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT         = 8,
   parameter int CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vend_panel_ctrl_if.master    bus,
   input  logic                 coin_in,
   input  logic                 sel_btn,
   input  logic                 refund_btn,
   input  logic                 err_clr,
   output logic                 credit,
   output logic                 busy,
   output logic [CNT_W-1:0]     vend_count,
   output logic                 timeout_err
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CREDIT   = 2'd1,
      WAIT_BEV = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DB_W-1:0]  db_q [3];
   logic [DB_W-1:0]  db_d [3];
   logic [2:0]       raw_s;
   logic [2:0]       ev_s;
   logic             win_coin_s, win_sel_s, win_ref_s;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_fire_s;
   logic             coin_q, coin_d;
   logic             sel_q, sel_d;
   logic             ref_q, ref_d;
   logic             credit_q, credit_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   // Index 0 = coin, 1 = select, 2 = refund
   assign raw_s = {refund_btn, sel_btn, coin_in};

   // Saturating debounce counters; event fires only on the edge the count reaches DB_MAX
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         db_d[i] = '0;
         ev_s[i] = 1'b0;
         if (raw_s[i]) begin
            if (db_q[i] == DB_MAX) begin
               db_d[i] = db_q[i];
            end else begin
               db_d[i] = db_q[i] + DB_W'(1);
            end
            ev_s[i] = (db_q[i] == DB_LAST);
         end else begin
            db_d[i] = '0;
            ev_s[i] = 1'b0;
         end
      end
   end

   assign win_ref_s  = ev_s[2];
   assign win_sel_s  = ev_s[1] & ~ev_s[2];
   assign win_coin_s = ev_s[0] & ~ev_s[1] & ~ev_s[2];

   // Next-state, command pulses and dispense timeout
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      coin_d     = 1'b0;
      sel_d      = 1'b0;
      ref_d      = 1'b0;
      tmo_fire_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_coin_s) begin
               coin_d  = 1'b1;
               state_d = CREDIT;
            end else begin
               state_d = IDLE;
            end
         end
         CREDIT: begin
            if (win_ref_s) begin
               ref_d   = 1'b1;
               state_d = IDLE;
            end else if (win_sel_s) begin
               sel_d   = 1'b1;
               tmo_d   = '0;
               state_d = WAIT_BEV;
            end else begin
               state_d = CREDIT;
            end
         end
         WAIT_BEV: begin
            if (bus.beverage) begin
               state_d = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_fire_s = 1'b1;
               state_d    = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      credit_d = (state_d != IDLE);
      busy_d   = (state_d == WAIT_BEV);

      // A timeout on the same edge as err_clr keeps the error set
      if (tmo_fire_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State, debounce and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tmo_q    <= '0;
         coin_q   <= 1'b0;
         sel_q    <= 1'b0;
         ref_q    <= 1'b0;
         credit_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            db_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         coin_q   <= coin_d;
         sel_q    <= sel_d;
         ref_q    <= ref_d;
         credit_q <= credit_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         for (int i = 0; i < 3; i++) begin
            db_q[i] <= db_d[i];
         end
      end
   end

   assign bus.coin      = coin_q;
   assign bus.selection = sel_q;
   assign bus.refund    = ref_q;
   assign credit        = credit_q;
   assign busy          = busy_q;
   assign timeout_err   = err_q;

`ifdef VEND_PANEL_STATS_EN
   logic             bev_ok_s;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;

   assign bev_ok_s = (state_q == WAIT_BEV) & bus.beverage;

   // Saturating count of confirmed dispenses
   always_comb begin
      vcnt_d = vcnt_q;
      if (bev_ok_s && (vcnt_q != {CNT_W{1'b1}})) begin
         vcnt_d = vcnt_q + CNT_W'(1);
      end else begin
         vcnt_d = vcnt_q;
      end
   end

   // Dispense counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vcnt_q <= '0;
      end else begin
         vcnt_q <= vcnt_d;
      end
   end

   assign vend_count = vcnt_q;
`else
   assign vend_count = '0;
`endif

endmodule

// File: tb/tb_vend_panel_ctrl.sv
// Directed bench for vend_panel_ctrl: cycle table for vend/refund/timeout, plus sequences
// for bounce rejection, reset mid-operation and counter saturation.
module tb_vend_panel_ctrl;

   localparam int VW = 2;
`ifdef VEND_PANEL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          coin_in, sel_btn, refund_btn, err_clr;
   logic          credit, busy, timeout_err;
   logic [VW-1:0] vend_count;

   vend_panel_ctrl_if bus ();

   vend_panel_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT         (8),
      .CNT_W           (VW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .coin_in     (coin_in),
      .sel_btn     (sel_btn),
      .refund_btn  (refund_btn),
      .err_clr     (err_clr),
      .credit      (credit),
      .busy        (busy),
      .vend_count  (vend_count),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in  = {coin_in, sel_btn, refund_btn, beverage, err_clr}
   // out = {coin, selection, refund, credit, busy, timeout_err}
   typedef struct packed {
      logic [4:0]    in;
      logic [5:0]    out;
      logic [VW-1:0] vc;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   pulses;

   function automatic logic [VW-1:0] vc_exp(input int n);
      if (!STATS) return '0;
      return (n > 3) ? VW'(3) : VW'(n);
   endfunction

   function automatic vec_t mk(input logic [4:0] i, input logic [5:0] o, input int n);
      vec_t v;
      v.in  = i;
      v.out = o;
      v.vc  = vc_exp(n);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [5:0] outs();
      return {bus.coin, bus.selection, bus.refund, credit, busy, timeout_err};
   endfunction

   // Apply inputs, advance one edge, sample 1 time unit later and check one-hot pulses
   task automatic step(input logic [4:0] i);
      {coin_in, sel_btn, refund_btn, bus.beverage, err_clr} = i;
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones({bus.coin, bus.selection, bus.refund}) <= 1), 32'd1);
      pulses += int'(bus.coin) + int'(bus.selection) + int'(bus.refund);
   endtask

   task automatic do_vend(input int n_after);
      for (int k = 0; k < 4; k++) step(5'b10000);
      step(5'b00000);
      for (int k = 0; k < 4; k++) step(5'b01000);
      step(5'b00000);
      step(5'b00010);
      step(5'b00000);
      chk("vend_count", 32'(vend_count), 32'(vc_exp(n_after)));
   endtask

   initial begin
      rst_n = 1'b0;
      {coin_in, sel_btn, refund_btn, bus.beverage, err_clr} = 5'b00000;
      pulses = 0;

      // Basic vend
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b10000, 6'b000000, 0));
      vecs.push_back(mk(5'b10000, 6'b100100, 0));
      vecs.push_back(mk(5'b00000, 6'b000100, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b01000, 6'b000100, 0));
      vecs.push_back(mk(5'b01000, 6'b010110, 0));
      vecs.push_back(mk(5'b00000, 6'b000110, 0));
      vecs.push_back(mk(5'b00010, 6'b000000, 1));
      vecs.push_back(mk(5'b00000, 6'b000000, 1));
      // Refund beats selection on the same edge
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b10000, 6'b000000, 1));
      vecs.push_back(mk(5'b10000, 6'b100100, 1));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b01100, 6'b000100, 1));
      vecs.push_back(mk(5'b01100, 6'b001000, 1));
      vecs.push_back(mk(5'b00000, 6'b000000, 1));
      // Timeout, coin dropped in WAIT_BEV, stray beverage, err_clr
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b10000, 6'b000000, 1));
      vecs.push_back(mk(5'b10000, 6'b100100, 1));
      vecs.push_back(mk(5'b00000, 6'b000100, 1));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b01000, 6'b000100, 1));
      vecs.push_back(mk(5'b01000, 6'b010110, 1));
      for (int k = 0; k < 4; k++) vecs.push_back(mk(5'b10000, 6'b000110, 1));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(5'b00000, 6'b000110, 1));
      vecs.push_back(mk(5'b00000, 6'b000001, 1));
      vecs.push_back(mk(5'b00010, 6'b000001, 1));
      vecs.push_back(mk(5'b00001, 6'b000000, 1));
      vecs.push_back(mk(5'b00000, 6'b000000, 1));

      #12;
      chk("reset_outs", 32'(outs()), 32'd0);
      chk("reset_vc", 32'(vend_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].in);
         chk($sformatf("vec[%0d].out", i), 32'(outs()), 32'(vecs[i].out));
         chk($sformatf("vec[%0d].vc", i), 32'(vend_count), 32'(vecs[i].vc));
      end

      // Bounce rejection, then one pulse for a long steady press
      begin
         logic [7:0] bounce;
         bounce = 8'b1110_1110;
         pulses = 0;
         for (int k = 7; k >= 0; k--) step({bounce[k], 4'b0000});
         chk("bounce_no_pulse", 32'(pulses), 32'd0);
         for (int k = 0; k < 4; k++) step(5'b10000);
         chk("steady_coin", 32'(bus.coin), 32'd1);
         for (int k = 0; k < 20; k++) step(5'b10000);
         chk("held_one_pulse", 32'(pulses), 32'd1);
         chk("held_credit", 32'(credit), 32'd1);
         step(5'b00000);
         for (int k = 0; k < 4; k++) step(5'b00100);
         chk("refund_pulse", 32'(bus.refund), 32'd1);
         step(5'b00000);
         chk("refund_credit", 32'(credit), 32'd0);
      end

      // Reset in WAIT_BEV with a selection pulse in flight
      do_vend(2);
      for (int k = 0; k < 4; k++) step(5'b10000);
      step(5'b00000);
      for (int k = 0; k < 4; k++) step(5'b01000);
      chk("pre_rst_sel", 32'({bus.selection, busy}), 32'b11);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 32'(outs()), 32'd0);
      chk("midrst_vc", 32'(vend_count), 32'd0);
      {coin_in, sel_btn, refund_btn, bus.beverage, err_clr} = 5'b00000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) step(5'b00000);
      chk("post_rst_quiet", 32'(pulses), 32'd0);
      chk("post_rst_outs", 32'(outs()), 32'd0);

      // Saturation of the dispense counter
      for (int n = 1; n <= 5; n++) do_vend(n);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
